// File: rtl/bram_line_packer_if.sv
// Byte-stream and BRAM write-port signals for bram_line_packer.
// The master modport is the packer. The slave modport is the stream source and write-port side.
interface bram_line_packer_if #(
    parameter int IN_WIDTH   = 8,
    parameter int LINE_WIDTH = 512
);
    logic                  s_valid_i;
    logic [IN_WIDTH-1:0]   s_data_i;
    logic                  s_last_i;
    logic                  s_ready_o;
    logic                  wr_en_o;
    logic                  wr_valid_o;
    logic [LINE_WIDTH-1:0] wr_data_o;
    logic                  wr_finish_i;

    modport master (
        input  s_valid_i, s_data_i, s_last_i, wr_finish_i,
        output s_ready_o, wr_en_o, wr_valid_o, wr_data_o
    );

    modport slave (
        output s_valid_i, s_data_i, s_last_i, wr_finish_i,
        input  s_ready_o, wr_en_o, wr_valid_o, wr_data_o
    );
endinterface

// File: rtl/bram_line_packer.sv
// Packs a narrow valid/ready byte stream into LINE_WIDTH-bit lines and hands each line to the BRAM write port.
// A frame ends after LINE_COUNT lines, or earlier on s_last_i.
module bram_line_packer #(
    parameter int IN_WIDTH   = 8,
    parameter int LINE_WIDTH = 512,
    parameter int LINE_COUNT = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    bram_line_packer_if.master                bus,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [$clog2(LINE_COUNT+1)-1:0]   line_cnt_o
);
    localparam int BEATS = LINE_WIDTH / IN_WIDTH;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LC_W  = $clog2(LINE_COUNT + 1);
    localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BEATS - 1);
    localparam logic [LC_W-1:0] LINE_LAST = LC_W'(LINE_COUNT - 1);

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, DONE} state_t;

    state_t                state;
    logic [LINE_WIDTH-1:0] line_q;
    logic [BC_W-1:0]       beat_cnt;
    logic [LC_W-1:0]       line_cnt;
    logic                  last_seen;
    logic                  s_ready_q;
    logic                  wr_en_q;
    logic                  wr_valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  accept;

    // s_ready_q is only ever set while in FILL, so it doubles as the state qualifier
    assign accept = bus.s_valid_i & s_ready_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            line_q     <= '0;
            beat_cnt   <= '0;
            line_cnt   <= '0;
            last_seen  <= 1'b0;
            s_ready_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= FILL;
                        line_q    <= '0;
                        beat_cnt  <= '0;
                        line_cnt  <= '0;
                        last_seen <= 1'b0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        line_q[int'(beat_cnt)*IN_WIDTH +: IN_WIDTH] <= bus.s_data_i;
                        if (beat_cnt == BEAT_LAST || bus.s_last_i) begin
                            state      <= ISSUE;
                            last_seen  <= bus.s_last_i;
                            s_ready_q  <= 1'b0;
                            wr_en_q    <= 1'b1;
                            wr_valid_q <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    wr_valid_q <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (bus.wr_finish_i) begin
                        line_cnt <= line_cnt + 1'b1;
                        wr_en_q  <= 1'b0;
                        if (last_seen || line_cnt == LINE_LAST) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            // Clearing here leaves zeros in the unused slots of a short final line
                            state     <= FILL;
                            line_q    <= '0;
                            beat_cnt  <= '0;
                            s_ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready_o  = s_ready_q;
    assign bus.wr_en_o    = wr_en_q;
    assign bus.wr_valid_o = wr_valid_q;
    assign bus.wr_data_o  = line_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign line_cnt_o     = line_cnt;
endmodule

// File: tb/tb_bram_line_packer.sv
// Randomized bench for bram_line_packer.
// Expected lines are built from the offered byte lists; a per-cycle model tracks the handshake outputs.
module tb_bram_line_packer;
    localparam int IN_WIDTH   = 8;
    localparam int LINE_WIDTH = 512;
    localparam int LINE_COUNT = 16;
    localparam int BEATS      = LINE_WIDTH / IN_WIDTH;
    localparam int LC_W       = $clog2(LINE_COUNT + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy;
    logic            done;
    logic [LC_W-1:0] line_cnt;

    bram_line_packer_if #(.IN_WIDTH(IN_WIDTH), .LINE_WIDTH(LINE_WIDTH)) bus ();

    bram_line_packer #(
        .IN_WIDTH(IN_WIDTH), .LINE_WIDTH(LINE_WIDTH), .LINE_COUNT(LINE_COUNT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus),
        .busy_o(busy), .done_o(done), .line_cnt_o(line_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [LINE_WIDTH-1:0] got, input logic [LINE_WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input string detail);
        checks++;
        failures++;
        $display("FAIL %s %s", name, detail);
    endtask

    // Behavioural model state
    bit m_busy, m_ready, m_issue, m_wait, m_done, m_last;
    int m_nbytes, m_lines;
    logic [LINE_WIDTH-1:0] exp_lines[$];
    logic [LINE_WIDTH-1:0] got_lines[$];
    logic [LINE_WIDTH-1:0] cur_line;
    logic [7:0]            frame_bytes[$];

    logic resp_fin = 1'b0;
    logic stray_fin = 1'b0;
    bit   hold_fin = 1'b0;
    int   fin_lo = 0;
    int   fin_hi = 10;
    bit   saw_done;

    assign bus.wr_finish_i = resp_fin | stray_fin;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0; m_ready = 0; m_issue = 0; m_wait = 0; m_done = 0; m_last = 0;
            m_nbytes = 0; m_lines = 0;
            exp_lines.delete();
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_issue) begin
            m_issue = 0;
            m_wait = 1;
        end else if (m_wait) begin
            if (bus.wr_finish_i) begin
                m_lines++;
                m_wait = 0;
                m_nbytes = 0;
                if (m_last || m_lines == LINE_COUNT) m_done = 1;
                else m_ready = 1;
            end
        end else if (m_ready) begin
            if (bus.s_valid_i) begin
                m_nbytes++;
                if (m_nbytes == BEATS || bus.s_last_i) begin
                    m_ready = 0;
                    m_issue = 1;
                    m_last = bus.s_last_i;
                end
            end
        end else if (!m_busy && start) begin
            m_busy = 1; m_ready = 1; m_lines = 0; m_nbytes = 0; m_last = 0;
        end
    end

    // Compare process
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("s_ready", bus.s_ready_o, m_ready);
            chk("wr_en", bus.wr_en_o, m_issue | m_wait);
            chk("wr_valid", bus.wr_valid_o, m_issue);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("line_cnt", line_cnt, m_lines);
            if (bus.wr_valid_o) got_lines.push_back(bus.wr_data_o);
            if (m_issue) begin
                if (exp_lines.size() == 0) fail("unexpected_line", $sformatf("got=%0h exp=none", bus.wr_data_o));
                else begin
                    cur_line = exp_lines.pop_front();
                    chk("wr_data", bus.wr_data_o, cur_line);
                end
            end else if (m_wait) begin
                chk("wr_data_hold", bus.wr_data_o, cur_line);
            end
            if (m_done) chk("lines_left", exp_lines.size(), 0);
        end
    end

    // Write-port responder
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (bus.wr_valid_o && !hold_fin && !rst) begin
                d = $urandom_range(fin_hi, fin_lo);
                repeat (d) @(negedge clk);
                @(negedge clk);
                resp_fin = 1'b1;
                @(negedge clk);
                resp_fin = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic seq_bytes(input int n, input int base);
        frame_bytes.delete();
        for (int i = 0; i < n; i++) frame_bytes.push_back(8'(base + i));
    endtask

    task automatic expect_frame(input int n, input int last_idx);
        int take;
        logic [LINE_WIDTH-1:0] v;
        take = (last_idx >= 0) ? last_idx + 1 : n;
        if (take > LINE_COUNT * BEATS) take = LINE_COUNT * BEATS;
        for (int l = 0; l * BEATS < take; l++) begin
            v = '0;
            for (int b = 0; b < BEATS; b++)
                if (l * BEATS + b < take) v[b*IN_WIDTH +: IN_WIDTH] = frame_bytes[l*BEATS + b];
            exp_lines.push_back(v);
        end
    endtask

    task automatic do_start();
        saw_done = 0;
        got_lines.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int from, input int to, input int last_idx, input int gap, output int accepted);
        int idx;
        bit acc;
        int cyc;
        idx = from; acc = 0; cyc = 0; accepted = 0;
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (acc) begin idx++; accepted++; end
            if (done) saw_done = 1;
            if (idx >= to || saw_done) break;
            bus.s_valid_i = ($urandom_range(99, 0) >= gap);
            bus.s_data_i  = frame_bytes[idx];
            bus.s_last_i  = (idx == last_idx);
            acc = bus.s_valid_i && bus.s_ready_o;
        end
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
        if (cyc >= 20000) fail("send_timeout", $sformatf("got=%0d accepted exp=%0d", accepted, to - from));
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (!saw_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (done) saw_done = 1;
        end
        if (!saw_done) fail(name, "got=no_done exp=done_pulse");
    endtask

    logic [LINE_WIDTH-1:0] line_a;
    int acc_n;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.s_data_i = '0;
        bus.s_last_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", bus.s_ready_o, 0);
        chk("rst_wr_en", bus.wr_en_o, 0);
        chk("rst_wr_valid", bus.wr_valid_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_data", bus.wr_data_o, 0);
        chk("rst_line_cnt", line_cnt, 0);
        rst = 1'b0;

        // Incrementing bytes, one full line then a single-byte last line
        fin_lo = 2; fin_hi = 2;
        seq_bytes(65, 0);
        expect_frame(65, 64);
        do_start();
        send(0, 65, 64, 0, acc_n);
        wait_done("s1_done_timeout");
        chk("s1_nlines", got_lines.size(), 2);
        line_a = got_lines[0];
        chk("s1_lo", line_a[127:0], 128'h0f0e0d0c0b0a09080706050403020100);
        chk("s1_hi", line_a[511:384], 128'h3f3e3d3c3b3a39383736353433323130);
        chk("s1_tail", got_lines[1], 512'h40);
        chk("s1_line_cnt", line_cnt, 2);

        // Short early-terminated frame
        fin_lo = 0; fin_hi = 10;
        seq_bytes(5, 8'h11);
        expect_frame(5, 4);
        do_start();
        send(0, 5, 4, 0, acc_n);
        wait_done("s2_done_timeout");
        chk("s2_lo", got_lines[0][39:0], 40'h1514131211);
        chk("s2_rest_zero", got_lines[0][511:40], '0);
        repeat (3) @(negedge clk);
        chk("s2_line_cnt_hold", line_cnt, 1);

        // Stray start and finish while filling
        seq_bytes(20, 8'h80);
        expect_frame(20, 19);
        do_start();
        send(0, 10, 19, 0, acc_n);
        @(negedge clk);
        start = 1'b1;
        stray_fin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stray_fin = 1'b0;
        chk("s6_line_cnt", line_cnt, 0);
        chk("s6_busy", busy, 1);
        send(10, 20, 19, 0, acc_n);
        wait_done("s6_done_timeout");
        chk("s6_line", got_lines[0][159:0], 160'h939291908f8e8d8c8b8a89888786858483828180);

        // Full frame with more bytes offered than fit
        fin_lo = 0; fin_hi = 3;
        frame_bytes.delete();
        for (int i = 0; i < LINE_COUNT * BEATS + 6; i++) frame_bytes.push_back(8'($urandom));
        expect_frame(LINE_COUNT * BEATS + 6, -1);
        do_start();
        send(0, LINE_COUNT * BEATS + 6, -1, 0, acc_n);
        wait_done("s3_done_timeout");
        chk("s3_accepted", acc_n, LINE_COUNT * BEATS);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.s_valid_i = 1'b1;
            bus.s_data_i = frame_bytes[LINE_COUNT * BEATS];
        end
        bus.s_valid_i = 1'b0;
        chk("s3_nlines", got_lines.size(), LINE_COUNT);
        chk("s3_line_cnt", line_cnt, LINE_COUNT);

        // Random input gaps and finish delays
        fin_lo = 0; fin_hi = 10;
        seq_bytes(65, 0);
        expect_frame(65, 64);
        do_start();
        send(0, 65, 64, 40, acc_n);
        wait_done("s4_done_timeout");
        chk("s4_same_as_s1", got_lines[0], line_a);

        // Reset while waiting for the write port
        hold_fin = 1;
        frame_bytes.delete();
        for (int i = 0; i < BEATS; i++) frame_bytes.push_back(8'h55);
        expect_frame(BEATS, -1);
        do_start();
        send(0, BEATS, -1, 0, acc_n);
        @(negedge clk);
        chk("s5_in_wait", bus.wr_en_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_wr_en", bus.wr_en_o, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_s_ready", bus.s_ready_o, 0);
        @(negedge clk);
        rst = 1'b0;
        hold_fin = 0;
        seq_bytes(1, 8'hAA);
        expect_frame(1, 0);
        do_start();
        send(0, 1, 0, 0, acc_n);
        wait_done("s5_done_timeout");
        chk("s5_byte", got_lines[0][7:0], 8'hAA);
        chk("s5_no_stale", got_lines[0][511:8], '0);
        chk("s5_line_cnt", line_cnt, 1);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
